// File: rtl/onehot_codec_pipe.sv
// onehot_codec_pipe: registered binary <-> one-hot converter behind a
// valid/ready handshake. mode_i = 0 decodes bin_i to one-hot, mode_i = 1
// encodes one_hot_i to binary (lowest set bit) and flags non-one-hot input.
// One output register stage, one beat per cycle at full throughput.
//
// Optional build macro ONEHOT_CODEC_ERR_CNT_EN adds a saturating 16-bit
// count of accepted error beats (err_cnt_o) with a synchronous clear
// (err_cnt_clr_i).
module onehot_codec_pipe #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 mode_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [BIN_W-1:0]     bin_i,
    input  logic [ONE_HOT_W-1:0] one_hot_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ONE_HOT_W-1:0] one_hot_o,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 mode_o,
    output logic                 err_o
`ifdef ONEHOT_CODEC_ERR_CNT_EN
    ,
    output logic [15:0]          err_cnt_o,
    input  logic                 err_cnt_clr_i
`endif
);

    logic                 accept;
    logic [ONE_HOT_W-1:0] dec_one_hot;
    logic                 dec_err;
    logic [BIN_W-1:0]     enc_bin;
    logic                 enc_err;
    logic [ONE_HOT_W-1:0] nxt_one_hot;
    logic [BIN_W-1:0]     nxt_bin;
    logic                 nxt_err;

    // Ready depends only on the output register and downstream ready,
    // never on in_valid_i.
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // Decode: a code beyond the one-hot width matches no bit, which is
    // exactly the out-of-range error case.
    always_comb begin
        dec_one_hot = '0;
        for (int i = 0; i < ONE_HOT_W; i++) begin
            dec_one_hot[i] = (bin_i == BIN_W'(i));
        end
        dec_err = ~|dec_one_hot;
    end

    // Encode: scan high to low so the lowest set bit wins; error unless
    // exactly one bit is set (x & (x-1) clears the lowest set bit).
    always_comb begin
        enc_bin = '0;
        for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
            if (one_hot_i[i]) begin
                enc_bin = BIN_W'(i);
            end
        end
        enc_err = (one_hot_i == '0) ||
                  ((one_hot_i & (one_hot_i - ONE_HOT_W'(1))) != '0);
    end

    // Select the result for the beat's mode; the unused field is zeroed.
    always_comb begin
        nxt_one_hot = '0;
        nxt_bin     = '0;
        nxt_err     = 1'b0;
        if (mode_i) begin
            nxt_bin = enc_bin;
            nxt_err = enc_err;
        end else begin
            nxt_one_hot = dec_one_hot;
            nxt_err     = dec_err;
        end
    end

    // Output register: load on accept, drop valid on a drain with no new
    // beat; data holds its last value when not loading.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            one_hot_o   <= '0;
            bin_o       <= '0;
            mode_o      <= 1'b0;
            err_o       <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            one_hot_o   <= nxt_one_hot;
            bin_o       <= nxt_bin;
            mode_o      <= mode_i;
            err_o       <= nxt_err;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef ONEHOT_CODEC_ERR_CNT_EN
    logic [15:0] err_cnt;

    // Saturating count of accepted error beats; clear has priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt <= '0;
        end else if (err_cnt_clr_i) begin
            err_cnt <= '0;
        end else if (accept && nxt_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`endif

endmodule
